// File: rtl/nfca_pkg.sv
// nfca_pkg: types and default timing shared by the NFC-A transmit and receive bit layers.
package nfca_pkg;

    // Default slot length (128 carrier periods at 81.36 MHz) and pause width (~2.5 us).
    localparam int NFCA_SLOT_CLKS  = 768;
    localparam int NFCA_PAUSE_CLKS = 204;

    // Modified-Miller sequences: X = late pause, Y = no pause, Z = early pause.
    typedef enum logic [1:0] {SEQ_X, SEQ_Y, SEQ_Z} tx_seq_t;

    typedef enum logic [2:0] {ST_IDLE, ST_SOC, ST_DATA, ST_EOC0, ST_EOC1} tx_state_t;

    // A logic 1 is always X; a logic 0 is Z after S or another 0, otherwise Y.
    function automatic tx_seq_t enc_bit(input logic b, input logic prev_zero);
        tx_seq_t s;
        if (b) begin
            s = SEQ_X;
        end else if (prev_zero) begin
            s = SEQ_Z;
        end else begin
            s = SEQ_Y;
        end
        return s;
    endfunction

endpackage

// File: rtl/nfca_tx_seqgen.sv
// nfca_tx_seqgen: turns the current slot sequence and slot offset into the registered pause envelope.
module nfca_tx_seqgen
    import nfca_pkg::*;
#(
    parameter int SLOT_CLKS  = NFCA_SLOT_CLKS,
    parameter int PAUSE_CLKS = NFCA_PAUSE_CLKS,
    parameter int CNT_W      = $clog2(SLOT_CLKS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  tx_seq_t          seq,
    input  logic [CNT_W-1:0] cnt,
    output logic             tx_pause
);
    localparam int HALF = SLOT_CLKS / 2;

    logic pause_d, pause_q;

    // Offset comparator: Z pauses at the slot start, X at mid-slot, Y never.
    always_comb begin
        pause_d = 1'b0;
        if (en) begin
            case (seq)
                SEQ_Z:   pause_d = (cnt < CNT_W'(PAUSE_CLKS));
                SEQ_X:   pause_d = (cnt >= CNT_W'(HALF)) && (cnt < CNT_W'(HALF + PAUSE_CLKS));
                default: pause_d = 1'b0;
            endcase
        end
    end

    // One-cycle register so every pause is exactly PAUSE_CLKS wide and glitch-free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_d;
        end
    end

    assign tx_pause = pause_q;

endmodule

// File: rtl/nfca_tx_tobits.sv
// nfca_tx_tobits: ISO14443A 106 kbps PCD bit encoder (Modified Miller), adds S and E itself.
// Optional build macro NFCA_TX_PARITY_EN: insert an odd-parity slot after every 8 data bits.
module nfca_tx_tobits
    import nfca_pkg::*;
#(
    parameter int SLOT_CLKS  = NFCA_SLOT_CLKS,
    parameter int PAUSE_CLKS = NFCA_PAUSE_CLKS
) (
    input  logic rstn,
    input  logic clk,
    input  logic tx_on,
    input  logic tx_start,
    input  logic tx_bit_valid,
    input  logic tx_bit,
    input  logic tx_bit_last,
    output logic tx_bit_ready,
    output logic tx_pause,
    output logic tx_busy,
    output logic tx_done,
    output logic tx_underrun
);
    localparam int               CNT_W     = $clog2(SLOT_CLKS);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CLKS - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tx_seq_t          seq_q, seq_d;
    logic slot_zero_q, slot_zero_d;   // current slot is S or a logic 0
    logic hold_full_q, hold_full_d;
    logic hold_bit_q, hold_bit_d;
    logic hold_last_q, hold_last_d;
    logic last_seen_q, last_seen_d;   // the frame's last bit has been accepted
    logic cur_last_q, cur_last_d;     // the bit on air carries last
    logic underrun_q, underrun_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic under_out_q, under_out_d;
    logic ready_q, ready_d;
    logic slot_end, xfer, consume, seq_en;
`ifdef NFCA_TX_PARITY_EN
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic       par_q, par_d;
`endif

    assign slot_end = (cnt_q == SLOT_LAST);
    assign xfer     = tx_bit_valid && ready_q;
    assign seq_en   = tx_on && (state_q != ST_IDLE);

    // Next-state: frame sequencing, slot boundary decisions and the holding register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        slot_zero_d = slot_zero_q;
        hold_full_d = hold_full_q;
        hold_bit_d  = hold_bit_q;
        hold_last_d = hold_last_q;
        last_seen_d = last_seen_q;
        cur_last_d  = cur_last_q;
        underrun_d  = underrun_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        under_out_d = 1'b0;
        consume     = 1'b0;
`ifdef NFCA_TX_PARITY_EN
        byte_cnt_d  = byte_cnt_q;
        par_d       = par_q;
`endif
        if (!tx_on) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            hold_full_d = 1'b0;
            last_seen_d = 1'b0;
            cur_last_d  = 1'b0;
            underrun_d  = 1'b0;
            busy_d      = 1'b0;
        end else begin
            if (state_q != ST_IDLE) begin
                cnt_d = slot_end ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        state_d     = ST_SOC;
                        cnt_d       = '0;
                        seq_d       = SEQ_Z;
                        slot_zero_d = 1'b1;
                        busy_d      = 1'b1;
                        hold_full_d = 1'b0;
                        last_seen_d = 1'b0;
                        cur_last_d  = 1'b0;
                        underrun_d  = 1'b0;
`ifdef NFCA_TX_PARITY_EN
                        byte_cnt_d  = '0;
                        par_d       = 1'b0;
`endif
                    end
                end
                ST_SOC, ST_DATA: begin
                    if (slot_end) begin
`ifdef NFCA_TX_PARITY_EN
                        if (byte_cnt_q == 4'd8) begin
                            // Parity slot: bit value is ~par_q, nothing is consumed.
                            state_d     = ST_DATA;
                            seq_d       = enc_bit(~par_q, slot_zero_q);
                            slot_zero_d = par_q;
                            byte_cnt_d  = '0;
                            par_d       = 1'b0;
                        end else
`endif
                        if (cur_last_q || !hold_full_q) begin
                            state_d     = ST_EOC0;
                            seq_d       = enc_bit(1'b0, slot_zero_q);
                            slot_zero_d = 1'b1;
                            underrun_d  = !cur_last_q;
                        end else begin
                            consume     = 1'b1;
                            state_d     = ST_DATA;
                            seq_d       = enc_bit(hold_bit_q, slot_zero_q);
                            slot_zero_d = !hold_bit_q;
                            cur_last_d  = hold_last_q;
`ifdef NFCA_TX_PARITY_EN
                            byte_cnt_d  = byte_cnt_q + 4'd1;
                            par_d       = par_q ^ hold_bit_q;
`endif
                        end
                    end
                end
                ST_EOC0: begin
                    if (slot_end) begin
                        state_d     = ST_EOC1;
                        seq_d       = SEQ_Y;
                        slot_zero_d = 1'b0;
                    end
                end
                ST_EOC1: begin
                    if (slot_end) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        under_out_d = underrun_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // A transfer in the same cycle as a consume keeps the register full.
            if (xfer) begin
                hold_full_d = 1'b1;
                hold_bit_d  = tx_bit;
                hold_last_d = tx_bit_last;
                if (tx_bit_last) begin
                    last_seen_d = 1'b1;
                end
            end else if (consume) begin
                hold_full_d = 1'b0;
            end
        end
        ready_d = busy_d && !hold_full_d && !last_seen_d &&
                  ((state_d == ST_SOC) || (state_d == ST_DATA));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seq_q       <= SEQ_Y;
            slot_zero_q <= 1'b0;
            hold_full_q <= 1'b0;
            hold_bit_q  <= 1'b0;
            hold_last_q <= 1'b0;
            last_seen_q <= 1'b0;
            cur_last_q  <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            under_out_q <= 1'b0;
            ready_q     <= 1'b0;
`ifdef NFCA_TX_PARITY_EN
            byte_cnt_q  <= '0;
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            slot_zero_q <= slot_zero_d;
            hold_full_q <= hold_full_d;
            hold_bit_q  <= hold_bit_d;
            hold_last_q <= hold_last_d;
            last_seen_q <= last_seen_d;
            cur_last_q  <= cur_last_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            under_out_q <= under_out_d;
            ready_q     <= ready_d;
`ifdef NFCA_TX_PARITY_EN
            byte_cnt_q  <= byte_cnt_d;
            par_q       <= par_d;
`endif
        end
    end

    nfca_tx_seqgen #(
        .SLOT_CLKS  (SLOT_CLKS),
        .PAUSE_CLKS (PAUSE_CLKS),
        .CNT_W      (CNT_W)
    ) u_seqgen (
        .clk      (clk),
        .rstn     (rstn),
        .en       (seq_en),
        .seq      (seq_q),
        .cnt      (cnt_q),
        .tx_pause (tx_pause)
    );

    assign tx_bit_ready = ready_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign tx_underrun  = under_out_q;

endmodule

// File: tb/tb_nfca_tx_tobits.sv
// tb_nfca_tx_tobits: directed and randomized frames checked against a slot-level Modified-Miller model.
module tb_nfca_tx_tobits;
    localparam int SLOT = 768;
    localparam int PW   = 204;
    localparam int HALF = SLOT / 2;
`ifdef NFCA_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn, tx_on, tx_start, tx_bit_valid, tx_bit, tx_bit_last;
    logic tx_bit_ready, tx_pause, tx_busy, tx_done, tx_underrun;
    int   checks = 0;
    int   errors = 0;
    bit   fb[$];

    always #5 clk = ~clk;

    nfca_tx_tobits #(.SLOT_CLKS(SLOT), .PAUSE_CLKS(PW)) dut (
        .rstn         (rstn),
        .clk          (clk),
        .tx_on        (tx_on),
        .tx_start     (tx_start),
        .tx_bit_valid (tx_bit_valid),
        .tx_bit       (tx_bit),
        .tx_bit_last  (tx_bit_last),
        .tx_bit_ready (tx_bit_ready),
        .tx_pause     (tx_pause),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_underrun  (tx_underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_bits(input logic [31:0] v, input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(v[i]);
    endtask

    // Sends fb (only the first navail bits are ever offered) and checks the whole envelope.
    task automatic run_frame(input string name, input int navail, input int start_at, input int drop_at);
        int seqs[$];   // 0 = Y, 1 = Z, 2 = X
        bit sent[$];
        bit pz, und, xfer_pend, dropped, prev_p, ep;
        int L, idx, perr, berr, rbad, rises, erises, s, off, dseen;
        for (int i = 0; i < navail; i++) begin
            sent.push_back(fb[i]);
            if (PAR_EN && (i % 8 == 7)) begin
                bit p;
                p = 1'b1;
                for (int j = i - 7; j <= i; j++) p = p ^ fb[j];
                sent.push_back(p);
            end
        end
        und = (navail < fb.size());
        seqs.push_back(1);
        pz = 1'b1;
        foreach (sent[i]) begin
            if (sent[i]) begin
                seqs.push_back(2);
                pz = 1'b0;
            end else begin
                seqs.push_back(pz ? 1 : 0);
                pz = 1'b1;
            end
        end
        seqs.push_back(pz ? 1 : 0);
        seqs.push_back(0);
        L = seqs.size() * SLOT;
        erises = 0;
        foreach (seqs[i]) if (seqs[i] != 0) erises++;

        idx = 0; perr = 0; berr = 0; rbad = 0; rises = 0;
        prev_p = 1'b0; xfer_pend = 1'b0; dropped = 1'b0;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        for (int k = 0; k <= L; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (xfer_pend) idx++;
            end
            ep = 1'b0;
            if (k > 0) begin
                s   = (k - 1) / SLOT;
                off = (k - 1) % SLOT;
                if (seqs[s] == 1)      ep = (off < PW);
                else if (seqs[s] == 2) ep = (off >= HALF) && (off < HALF + PW);
            end
            if (tx_pause !== ep) perr++;
            if (tx_pause && !prev_p) rises++;
            prev_p = tx_pause;
            if (k < L && (tx_busy !== 1'b1 || tx_done !== 1'b0)) berr++;
            if (tx_bit_ready && (idx >= fb.size() || k / SLOT >= seqs.size() - 2)) rbad++;
            if (k == 0) chk({name, "_ready_first_soc"}, tx_bit_ready, 1);
            if (k == L) begin
                chk({name, "_done"}, tx_done, 1);
                chk({name, "_busy_fall"}, tx_busy, 0);
                chk({name, "_underrun"}, tx_underrun, und);
            end
            if (k == drop_at) begin
                tx_on = 1'b0;
                tx_bit_valid = 1'b0;
                @(posedge clk); #1;
                chk({name, "_drop_pause"}, tx_pause, 0);
                chk({name, "_drop_busy"}, tx_busy, 0);
                chk({name, "_drop_ready"}, tx_bit_ready, 0);
                dseen = 0;
                repeat (20) begin
                    if (tx_done) dseen++;
                    @(posedge clk); #1;
                end
                chk({name, "_drop_no_done"}, dseen, 0);
                tx_on = 1'b1;
                dropped = 1'b1;
                break;
            end
            if (idx < navail) begin
                tx_bit_valid = ($urandom_range(0, 3) == 0);
                tx_bit       = fb[idx];
                tx_bit_last  = (idx == fb.size() - 1);
            end else begin
                tx_bit_valid = 1'b0;
            end
            xfer_pend = tx_bit_valid && tx_bit_ready;
            tx_start  = (k == start_at);
        end
        tx_start = 1'b0;
        tx_bit_valid = 1'b0;
        chk({name, "_pause_cycles_wrong"}, perr, 0);
        chk({name, "_busy_done_cycles_wrong"}, berr, 0);
        chk({name, "_ready_when_forbidden"}, rbad, 0);
        if (!dropped) begin
            chk({name, "_pause_count"}, rises, erises);
            @(posedge clk); #1;
            chk({name, "_done_one_cycle"}, tx_done, 0);
        end
    endtask

    initial begin
        rstn = 1'b0; tx_on = 1'b0; tx_start = 1'b0;
        tx_bit_valid = 1'b0; tx_bit = 1'b0; tx_bit_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pause", tx_pause, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ready", tx_bit_ready, 0);
        chk("rst_underrun", tx_underrun, 0);
        rstn = 1'b1;
        tx_on = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", tx_busy, 0);

        set_bits(32'h26, 7);
        run_frame("reqa", 7, -1, -1);

        set_bits(32'h1, 1);
        run_frame("single1", 1, -1, -1);

        set_bits(32'h16, 5);
        run_frame("underrun", 3, -1, -1);

        set_bits(32'h5, 3);
        run_frame("drop", 3, -1, SLOT + 400);

        set_bits(32'h0, 1);
        run_frame("restart", 1, -1, -1);

        set_bits(32'h2, 2);
        run_frame("start_busy", 2, 1000, -1);

`ifdef NFCA_TX_PARITY_EN
        set_bits(32'h93, 8);
        run_frame("parity93", 8, -1, -1);
`endif

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 8);
            set_bits($urandom, n);
            run_frame($sformatf("rand%0d", r), n, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
